// File: rtl/ledwheel_pll_supervisor.sv
// ledwheel_pll_supervisor: PLL reset sequencer and lock supervisor; define PLL_LOSS_COUNT_EN to build the lock-loss counter
module ledwheel_pll_supervisor #(
    parameter int HOLD_CYCLES   = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       sys_resetn,
    output logic       locked,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] loss_count
);
    localparam int MAX_A = HOLD_CYCLES > LOCK_TIMEOUT ? HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P = MAX_A > STABLE_CYCLES ? MAX_A : STABLE_CYCLES;
    localparam int CW = $clog2(MAX_P + 1);
    typedef enum logic [2:0] {S_HOLD, S_WAIT, S_STABLE, S_RUN, S_FAULT} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0] retry_nxt;
    logic lock_meta, lock_s;
    logic give_up, can_retry;
    logic pll_resetb_nxt, run_nxt, fault_nxt;
    // two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge clk) begin
        if (!reset) {lock_s, lock_meta} <= '0;
        else {lock_s, lock_meta} <= {lock_meta, pll_lock};
    end
    // state, cycle counter and retry counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_HOLD;
            cnt <= '0;
            retry_count <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            retry_count <= retry_nxt;
        end
    end
    assign can_retry = retry_count < 4'(MAX_RETRIES);
    assign give_up = !lock_s && (state == S_STABLE || (state == S_WAIT && cnt == CW'(LOCK_TIMEOUT - 1)));
    // next state: lock wins over timeout; losing lock while stabilising counts as a timeout
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt + CW'(1);
        retry_nxt = retry_count;
        case (state)
            S_HOLD: if (cnt == CW'(HOLD_CYCLES - 1)) begin
                state_nxt = S_WAIT;
                cnt_nxt = '0;
            end
            S_WAIT: if (lock_s) begin
                state_nxt = S_STABLE;
                cnt_nxt = '0;
            end
            S_STABLE: if (lock_s && cnt == CW'(STABLE_CYCLES - 1)) begin
                state_nxt = S_RUN;
                cnt_nxt = '0;
                retry_nxt = '0;
            end
            S_RUN: begin
                cnt_nxt = '0;
                if (!lock_s) state_nxt = S_HOLD;
            end
            default: cnt_nxt = '0;
        endcase
        if (give_up) begin
            state_nxt = can_retry ? S_HOLD : S_FAULT;
            cnt_nxt = '0;
            retry_nxt = can_retry ? retry_count + 4'd1 : retry_count;
        end
    end
    // output decode from the next state so the registered outputs track the state register
    always_comb begin
        pll_resetb_nxt = state_nxt == S_WAIT || state_nxt == S_STABLE || state_nxt == S_RUN;
        run_nxt = state_nxt == S_RUN;
        fault_nxt = state_nxt == S_FAULT;
    end
    // registered outputs, all deasserted under reset
    always_ff @(posedge clk) begin
        if (!reset) {pll_resetb, sys_resetn, locked, fault} <= '0;
        else {pll_resetb, sys_resetn, locked, fault} <= {pll_resetb_nxt, run_nxt, run_nxt, fault_nxt};
    end
`ifdef PLL_LOSS_COUNT_EN
    // saturating count of lock losses while running
    always_ff @(posedge clk) begin
        if (!reset) loss_count <= '0;
        else if (state == S_RUN && !lock_s && loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
    end
`else
    assign loss_count = 8'h00;
`endif
endmodule

// File: tb/tb_ledwheel_pll_supervisor.sv
// tb_ledwheel_pll_supervisor: table-driven scoreboard bench for ledwheel_pll_supervisor (4/16/8/2)
module tb_ledwheel_pll_supervisor;
`ifdef PLL_LOSS_COUNT_EN
    localparam bit LCE = 1'b1;
`else
    localparam bit LCE = 1'b0;
`endif
    typedef struct {
        logic        rst;
        logic        lock;
        int          n;
        logic [15:0] exp;
    } vec_t;
    logic clk = 1'b0;
    logic reset, pll_lock;
    logic pll_resetb, sys_resetn, locked, fault;
    logic [3:0] retry_count;
    logic [7:0] loss_count;
    logic [15:0] obs;
    logic [15:0] sb[$];
    vec_t vecs[$];
    int checks = 0;
    int fails = 0;
    bit ok;

    ledwheel_pll_supervisor #(
        .HOLD_CYCLES(4), .LOCK_TIMEOUT(16), .STABLE_CYCLES(8), .MAX_RETRIES(2)
    ) dut (
        .clk(clk), .reset(reset), .pll_lock(pll_lock),
        .pll_resetb(pll_resetb), .sys_resetn(sys_resetn), .locked(locked), .fault(fault),
        .retry_count(retry_count), .loss_count(loss_count)
    );

    always #5 clk = ~clk;
    assign obs = {pll_resetb, sys_resetn, locked, fault, retry_count, loss_count};

    function automatic vec_t mk(bit r, bit l, int n, bit pr, bit sr, bit lk, bit ft, int rc, int lc);
        vec_t v;
        v.rst = r;
        v.lock = l;
        v.n = n;
        v.exp = {pr, sr, lk, ft, 4'(rc), LCE ? 8'(lc) : 8'h00};
        return v;
    endfunction

    task automatic check(input string name);
        logic [15:0] e;
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            fails++;
            $display("FAIL %s: {pll_resetb,sys_resetn,locked,fault,retry,loss} got=%h want=%h", name, obs, e);
        end
    endtask

    task automatic wait_locked(input logic v, input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(posedge clk);
            #1;
            got = (locked === v);
        end
    endtask

    initial begin
        // lock tied high: resetb after 4, system release after 13; short lock drop; reset mid-run
        vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 5, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 4, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 8, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
        // lock drops 5 cycles into stabilisation, then relocks and retries are cleared in run
        vecs.push_back(mk(1, 1, 9, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 2, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 4, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 8, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0, 0));
        // lock never arrives: three hold pulses then fault until reset
        vecs.push_back(mk(0, 0, 2, 0, 0, 0, 0, 0, 0));
        for (int p = 0; p < 3; p++) begin
            vecs.push_back(mk(1, 0, 3, 0, 0, 0, 0, p, 0));
            vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, p, 0));
            vecs.push_back(mk(1, 0, 15, 1, 0, 0, 0, p, 0));
            vecs.push_back(p < 2 ? mk(1, 0, 1, 0, 0, 0, 0, p + 1, 0) : mk(1, 0, 1, 0, 0, 0, 1, 2, 0));
        end
        vecs.push_back(mk(1, 1, 30, 0, 0, 0, 1, 2, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
        // lock arriving exactly on the timeout cycle wins over retry
        vecs.push_back(mk(0, 0, 2, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 17, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 7, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0, 0));
        reset = 1'b0;
        pll_lock = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            pll_lock = vecs[i].lock;
            sb.push_back(vecs[i].exp);
            repeat (vecs[i].n) @(posedge clk);
            #1;
            check($sformatf("row%0d", i));
        end
        // repeated lock losses in run: counter saturates at 255 when built
        for (int k = 0; k < 300; k++) begin
            pll_lock = 1'b0;
            @(posedge clk);
            #1;
            pll_lock = 1'b1;
            wait_locked(1'b0, 6, ok);
            if (!ok) begin
                checks++;
                fails++;
                $display("FAIL loss%0d_drop: locked stayed 1, want 0 within 6 cycles", k);
                break;
            end
            wait_locked(1'b1, 40, ok);
            if (!ok) begin
                checks++;
                fails++;
                $display("FAIL loss%0d_relock: locked stayed 0, want 1 within 40 cycles", k);
                break;
            end
            if (k == 254 || k == 299) begin
                sb.push_back({4'b1110, 4'd0, LCE ? 8'd255 : 8'd0});
                check($sformatf("loss_sat%0d", k + 1));
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ledwheel_pll_supervisor.md
LEDWHEEL_PLL_SUPERVISOR -- requirements
Module: ledwheel_pll_supervisor

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 16, the number of cycles PLL_RESETB is held low per reset pulse.
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 4096, the maximum number of cycles to wait for lock after PLL reset release.
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 256, the number of consecutive locked cycles required before system reset release.
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3, the number of PLL re-reset attempts allowed before FAULT (range 0..15).
REQ-005 The block SHALL have port CLK, input, 1 bit: free-running 80 MHz reference clock (the PLL input clock).
REQ-006 The block SHALL have port RESET, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port PLL_LOCK, input, 1 bit: PLL lock indication, asynchronous to CLK.
REQ-008 The block SHALL have port PLL_RESETB, output, 1 bit: active-low reset to the PLL RESET input.
REQ-009 The block SHALL have port SYS_RESETN, output, 1 bit: active-low reset for the 25 MHz LED-wheel logic.
REQ-010 The block SHALL have port LOCKED, output, 1 bit: high only in state RUN.
REQ-011 The block SHALL have port FAULT, output, 1 bit: high only in state FAULT.
REQ-012 The block SHALL have port RETRY_COUNT, output, 4 bits: retries consumed since the last entry to RUN or reset.
REQ-013 The block SHALL have port LOSS_COUNT, output, 8 bits: lock losses observed in RUN.

Function
REQ-014 PLL_LOCK SHALL pass through a 2-flop synchronizer; lock_s reflects PLL_LOCK 2 CLK edges later.
REQ-015 The FSM SHALL have states HOLD, WAIT, STABLE, RUN and FAULT; all outputs SHALL be registered and decoded from the state.
REQ-016 HOLD: PLL_RESETB=0, SYS_RESETN=0; after HOLD_CYCLES cycles it SHALL go to WAIT with the cycle counter cleared.
REQ-017 WAIT: PLL_RESETB=1, SYS_RESETN=0; lock_s=1 SHALL go to STABLE with the counter cleared.
REQ-018 WAIT: when the counter reaches LOCK_TIMEOUT-1 without lock_s and RETRY_COUNT<MAX_RETRIES, the FSM SHALL increment RETRY_COUNT and go to HOLD.
REQ-019 WAIT: on timeout with RETRY_COUNT=MAX_RETRIES, the FSM SHALL go to FAULT.
REQ-020 When lock_s=1 on the timeout cycle, STABLE SHALL take priority over retry or FAULT.
REQ-021 STABLE: lock_s=0 SHALL be treated as a timeout: retry to HOLD per REQ-018, or FAULT per REQ-019.
REQ-022 STABLE: STABLE_CYCLES consecutive cycles with lock_s=1 SHALL go to RUN and clear RETRY_COUNT.
REQ-023 RUN: SYS_RESETN=1 and LOCKED=1; lock_s=0 SHALL go to HOLD, and SYS_RESETN=0 on the following edge.
REQ-024 FAULT: PLL_RESETB=0, SYS_RESETN=0, FAULT=1; the state SHALL be left only by RESET.
REQ-025 Counters SHALL be sized to hold the largest parameter and SHALL never wrap.

Reset
REQ-026 RESET=0 at a CLK edge SHALL force state HOLD, the counter to 0, RETRY_COUNT=0, LOSS_COUNT=0 and both synchronizer flops to 0.
REQ-027 Under RESET, the outputs SHALL be PLL_RESETB=0, SYS_RESETN=0, LOCKED=0 and FAULT=0.
REQ-028 RESET SHALL take priority over every FSM transition, including mid-RUN and in FAULT.

Configuration
REQ-029 With macro PLL_LOSS_COUNT_EN defined, each RUN→HOLD transition SHALL increment LOSS_COUNT, saturating at 255.
REQ-030 Without PLL_LOSS_COUNT_EN, no counter SHALL be built and LOSS_COUNT SHALL be constant 8'h00; all other behaviour SHALL be unchanged.

Verification (parameters 4/16/8/2 for HOLD_CYCLES/LOCK_TIMEOUT/STABLE_CYCLES/MAX_RETRIES)
REQ-031 PLL_LOCK tied to 1, RESET released -> PLL_RESETB rises 4 cycles after release; SYS_RESETN and LOCKED rise 13 cycles after release.
REQ-032 PLL_LOCK tied to 0 -> exactly 3 HOLD pulses of 4 cycles, then FAULT=1, RETRY_COUNT=2, PLL_RESETB stuck at 0 until RESET.
REQ-033 In RUN, a 1-cycle drop of PLL_LOCK -> SYS_RESETN=0 within 4 cycles, LOSS_COUNT 0→1; after relock, RUN is re-entered.
REQ-034 PLL_LOCK drops 5 cycles into STABLE -> HOLD, RETRY_COUNT=1, and SYS_RESETN never goes high.
REQ-035 RESET asserted mid-RUN -> next edge: SYS_RESETN=0, LOCKED=0, LOSS_COUNT=0, state HOLD.
REQ-036 300 lock losses in RUN -> LOSS_COUNT=255 with PLL_LOSS_COUNT_EN defined; LOSS_COUNT=0 without it.
